// File: rtl/dadda_mul16_seq.sv
// -----------------------------------------------------------------------------
// dadda_mul16_seq
//
// 16x16 unsigned sequential multiplier.  A single 8x8 Dadda-tree multiplier is
// time-multiplexed over four cycles.  The four byte-by-byte partial products
// are shifted and summed into a 32-bit accumulator.  Requests and results use
// valid/ready handshakes.  A request tag travels with each operation.
//
// Ports (dadda_mul16_seq):
//   clock       in   1      system clock, rising edge
//   reset       in   1      asynchronous active-high reset
//   in_valid    in   1      request valid
//   in_ready    out  1      request can be accepted this cycle
//   in_a        in   16     unsigned multiplicand
//   in_b        in   16     unsigned multiplier
//   in_tag      in   TAG_W  request tag
//   out_valid   out  1      result valid
//   out_ready   in   1      sink accepts result this cycle
//   out_data    out  32     product in_a*in_b
//   out_tag     out  TAG_W  tag belonging to out_data
//   busy        out  1      operation in flight (MUL or DONE)
//   done_count  out  16     completed result handshakes, wrapping
//
// Ports (DADDA_8x8_52):
//   a    in   8   unsigned operand
//   b    in   8   unsigned operand
//   out  out  16  a*b
// -----------------------------------------------------------------------------

module DADDA_8x8_52 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] out
);

  // Dadda column heights targeted by each reduction stage, tallest first.
  localparam int N_STAGES = 4;
  localparam int N_COLS   = 16;
  localparam int MAX_H    = 8;

  // Full adder sum/carry pair packed as {carry, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic z);
    full_add = {(x & y) | (x & z) | (y & z), x ^ y ^ z};
  endfunction

  // Half adder sum/carry pair packed as {carry, sum}.
  function automatic logic [1:0] half_add(input logic x, input logic y);
    half_add = {x & y, x ^ y};
  endfunction

  // Build the 8x8 AND-array, compress it to two rows with Dadda stages
  // (heights 6, 4, 3, 2), then add the two remaining rows.
  function automatic logic [15:0] dadda_product(input logic [7:0] x, input logic [7:0] y);
    logic [MAX_H-1:0] m  [N_COLS];
    logic [MAX_H-1:0] nm [N_COLS];
    int               h  [N_COLS];
    int               nh [N_COLS];
    int               stage_h [N_STAGES];
    int               excess;
    int               p;
    logic [1:0]       cs;
    logic [15:0]      row0;
    logic [15:0]      row1;

    stage_h = '{6, 4, 3, 2};
    for (int c = 0; c < N_COLS; c++) begin
      m[c] = {MAX_H{1'b0}};
      h[c] = 0;
    end

    // Partial-product bit a[i]&b[j] has weight i+j.
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        m[i + j][h[i + j]] = x[i] & y[j];
        h[i + j] = h[i + j] + 1;
      end
    end

    for (int s = 0; s < N_STAGES; s++) begin
      for (int c = 0; c < N_COLS; c++) begin
        nm[c] = {MAX_H{1'b0}};
        nh[c] = 0;
      end
      // Carries generated in column c land in nm[c+1] before that column is
      // processed, so each column only reduces what exceeds the target once
      // the incoming carries are counted.
      for (int c = 0; c < N_COLS; c++) begin
        excess = h[c] + nh[c] - stage_h[s];
        p = 0;
        for (int k = 0; k < 4; k++) begin
          if (excess >= 2) begin
            cs = full_add(m[c][p], m[c][p + 1], m[c][p + 2]);
            nm[c][nh[c]] = cs[0];
            nh[c] = nh[c] + 1;
            if (c < N_COLS - 1) begin
              nm[c + 1][nh[c + 1]] = cs[1];
              nh[c + 1] = nh[c + 1] + 1;
            end
            p = p + 3;
            excess = excess - 2;
          end
        end
        if (excess == 1) begin
          cs = half_add(m[c][p], m[c][p + 1]);
          nm[c][nh[c]] = cs[0];
          nh[c] = nh[c] + 1;
          if (c < N_COLS - 1) begin
            nm[c + 1][nh[c + 1]] = cs[1];
            nh[c + 1] = nh[c + 1] + 1;
          end
          p = p + 2;
        end
        // Bits not consumed by an adder pass straight through.
        for (int r = 0; r < MAX_H; r++) begin
          if ((r >= p) && (r < h[c])) begin
            nm[c][nh[c]] = m[c][r];
            nh[c] = nh[c] + 1;
          end
        end
      end
      for (int c = 0; c < N_COLS; c++) begin
        m[c] = nm[c];
        h[c] = nh[c];
      end
    end

    for (int c = 0; c < N_COLS; c++) begin
      row0[c] = m[c][0];
      row1[c] = m[c][1];
    end
    dadda_product = row0 + row1;
  endfunction

  // Combinational product.
  always_comb begin
    out = dadda_product(a, b);
  end

endmodule

module dadda_mul16_seq #(
  parameter int TAG_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy,
  output logic [15:0]      done_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [15:0]      a_r;
  logic [15:0]      b_r;
  logic [TAG_W-1:0] tag_r;
  logic [31:0]      acc_r;
  logic [1:0]       step_r;
  logic [15:0]      done_count_r;

  logic [7:0]       mul_a_s;
  logic [7:0]       mul_b_s;
  logic [15:0]      pp_s;
  logic [31:0]      pp_shift_s;
  logic             accept_s;
  logic             out_fire_s;

  // Operand byte selection: step[1] picks the a byte, step[0] the b byte.
  always_comb begin
    mul_a_s = step_r[1] ? a_r[15:8] : a_r[7:0];
    mul_b_s = step_r[0] ? b_r[15:8] : b_r[7:0];
  end

  DADDA_8x8_52 u_mul (
    .a   (mul_a_s),
    .b   (mul_b_s),
    .out (pp_s)
  );

  // Align the partial product to its byte-pair weight.
  always_comb begin
    pp_shift_s = 32'd0;
    case (step_r)
      2'd0:    pp_shift_s = {16'd0, pp_s};
      2'd1:    pp_shift_s = {8'd0, pp_s, 8'd0};
      2'd2:    pp_shift_s = {8'd0, pp_s, 8'd0};
      2'd3:    pp_shift_s = {pp_s, 16'd0};
      default: pp_shift_s = 32'd0;
    endcase
  end

  // Handshake decode; in_ready reaches back to out_ready so that a result
  // can retire and a new request enter on the same edge.
  always_comb begin
    in_ready   = (state_r == ST_IDLE) || ((state_r == ST_DONE) && out_ready);
    out_valid  = (state_r == ST_DONE);
    busy       = (state_r == ST_MUL) || (state_r == ST_DONE);
    accept_s   = in_valid && in_ready;
    out_fire_s = out_valid && out_ready;
  end

  // Next-state logic; the unused encoding falls back to IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          state_nxt_s = ST_MUL;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (step_r == 2'd3) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_MUL;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_nxt_s = in_valid ? ST_MUL : ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, operand latches, accumulator and completion counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      a_r          <= 16'd0;
      b_r          <= 16'd0;
      tag_r        <= {TAG_W{1'b0}};
      acc_r        <= 32'd0;
      step_r       <= 2'd0;
      done_count_r <= 16'd0;
    end else begin
      state_r <= state_nxt_s;
      if (accept_s) begin
        a_r    <= in_a;
        b_r    <= in_b;
        tag_r  <= in_tag;
        acc_r  <= 32'd0;
        step_r <= 2'd0;
      end else if (state_r == ST_MUL) begin
        acc_r  <= acc_r + pp_shift_s;
        step_r <= step_r + 2'd1;
      end
      if (out_fire_s) begin
        done_count_r <= done_count_r + 16'd1;
      end
    end
  end

  // Result outputs come straight from registers.
  always_comb begin
    out_data   = acc_r;
    out_tag    = tag_r;
    done_count = done_count_r;
  end

endmodule

// File: tb/tb_dadda_mul16_seq.sv
module tb_dadda_mul16_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_tag;
  logic        busy;
  logic [15:0] done_count;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          exp_done = 0;
  logic [35:0] exp_q[$];   // {tag, product} per accepted request, in order

  always #5 clock = ~clock;

  dadda_mul16_seq #(.TAG_W(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_tag    (out_tag),
    .busy       (busy),
    .done_count (done_count)
  );

  function automatic logic [31:0] golden(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] wa;
    logic [31:0] wb;
    wa = {16'd0, a};
    wb = {16'd0, b};
    golden = wa * wb;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset(input int cycles);
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      in_a      = 16'($urandom);
      in_b      = 16'($urandom);
      in_tag    = 4'($urandom);
      @(negedge clock);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_data", out_data, 32'd0);
      check("rst_out_tag", {28'd0, out_tag}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done_count", {16'd0, done_count}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    end
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    exp_q.delete();
    exp_done = 0;
  endtask

  // Present a request, wait (bounded) for acceptance, log it in the model.
  // Returns at the negedge right after the accept edge.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [3:0] t);
    int k;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_tag   = t;
    k = 0;
    while (!in_ready && k < 40) begin
      @(negedge clock);
      k++;
    end
    check("issue_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clock);
    exp_q.push_back({t, golden(a, b)});
    @(negedge clock);
    in_valid = 1'b0;
    in_a     = 16'($urandom);
    in_b     = 16'($urandom);
    in_tag   = 4'($urandom);
    check("busy_after_accept", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    check("result_timeout", {31'd0, out_valid}, 32'd1);
  endtask

  // Check the head result, stall it for a while, then hand it off.
  task automatic retire(input int stalls);
    logic [35:0] e;
    e = (exp_q.size() > 0) ? exp_q[0] : 36'd0;
    check("out_data", out_data, e[31:0]);
    check("out_tag", {28'd0, out_tag}, {28'd0, e[35:32]});
    for (int i = 0; i < stalls; i++) begin
      @(negedge clock);
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      check("stall_data", out_data, e[31:0]);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clock);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    exp_done++;
    @(negedge clock);
    out_ready = 1'b0;
    check("done_count", {16'd0, done_count}, {16'd0, 16'(exp_done)});
    check("valid_drop", {31'd0, out_valid}, 32'd0);
    check("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  logic [15:0] ext_a [4];
  logic [15:0] ext_b [4];
  logic [31:0] ext_p [4];

  initial begin
    int          lat;
    logic [35:0] e1;
    logic [15:0] ra;
    logic [15:0] rb;
    logic [3:0]  rt;

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_a      = 16'd0;
    in_b      = 16'd0;
    in_tag    = 4'd0;

    // Reset with random inputs, then idle with in_valid low.
    apply_reset(2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("idle_busy", {31'd0, busy}, 32'd0);
    end

    // Basic product with fixed latency.
    issue(16'h1234, 16'h5678, 4'd3);
    wait_result(lat);
    check("basic_latency", 32'(lat), 32'd4);
    check("basic_const", out_data, 32'h06260060);
    retire(0);
    check("basic_count", {16'd0, done_count}, 32'd1);

    // Extremes.
    ext_a = '{16'hFFFF, 16'h00FF, 16'hFF00, 16'h0000};
    ext_b = '{16'hFFFF, 16'h00FF, 16'h0100, 16'hABCD};
    ext_p = '{32'hFFFE0001, 32'h0000FE01, 32'h00FF0000, 32'h00000000};
    for (int i = 0; i < 4; i++) begin
      issue(ext_a[i], ext_b[i], 4'(i + 5));
      wait_result(lat);
      check("ext_const", out_data, ext_p[i]);
      retire(1);
    end

    // Backpressure with a queued request; retire and accept share an edge.
    issue(16'hBEEF, 16'h1357, 4'd9);
    wait_result(lat);
    e1 = exp_q[0];
    in_valid = 1'b1;
    in_a     = 16'h2468;
    in_b     = 16'hC0DE;
    in_tag   = 4'd12;
    for (int i = 0; i < 3; i++) begin
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_data", out_data, e1[31:0]);
      check("bp_tag", {28'd0, out_tag}, {28'd0, e1[35:32]});
      @(negedge clock);
    end
    out_ready = 1'b1;
    #1;
    check("bp_ready_comb", {31'd0, in_ready}, 32'd1);
    @(posedge clock);
    void'(exp_q.pop_front());
    exp_done++;
    exp_q.push_back({4'd12, golden(16'h2468, 16'hC0DE)});
    @(negedge clock);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("bp_valid_drop", {31'd0, out_valid}, 32'd0);
    check("bp_busy", {31'd0, busy}, 32'd1);
    check("bp_count", {16'd0, done_count}, {16'd0, 16'(exp_done)});
    wait_result(lat);
    check("bp_latency", 32'(lat), 32'd4);
    retire(0);

    // Abort in the step-2 cycle.
    issue(16'h7777, 16'h8888, 4'd1);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("abort_valid", {31'd0, out_valid}, 32'd0);
    check("abort_count", {16'd0, done_count}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    exp_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      check("abort_no_result", {31'd0, out_valid}, 32'd0);
    end
    issue(16'h0F0F, 16'hF00D, 4'd14);
    wait_result(lat);
    check("post_abort_latency", 32'(lat), 32'd4);
    retire(0);

    // Random stream with random result stalls.
    apply_reset(2);
    for (int i = 0; i < 100; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rt = 4'($urandom);
      issue(ra, rb, rt);
      wait_result(lat);
      check("rand_latency", 32'(lat), 32'd4);
      retire(int'($urandom_range(0, 3)));
    end
    check("rand_count", {16'd0, done_count}, 32'd100);
    check("rand_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
